// File: rtl/spi_adc_responder.sv
// SPI slave that returns a host-supplied 12-bit conversion value and latches a
// 16-bit command word. The channel address in the command applies to the next frame.
module spi_adc_responder #(
  parameter logic [2:0] RESET_CH = 3'd0,
  parameter int         SYNC     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  input  logic [11:0] sample,
  output logic [2:0]  chan,
  output logic [15:0] cmd,
  output logic        done,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam int              WARM_W   = $clog2(SYNC + 2);
  localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(SYNC + 1);

  logic [SYNC-1:0]   sclk_sync_q, sclk_sync_d;
  logic [SYNC-1:0]   ss_sync_q, ss_sync_d;
  logic [SYNC-1:0]   mosi_sync_q, mosi_sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic              ss_prev_q, ss_prev_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [2:0]        state_q, state_d;
  logic [15:0]       tx_q, tx_d;
  logic [15:0]       rx_q, rx_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              miso_q, miso_d;
  logic [15:0]       cmd_q, cmd_d;
  logic [2:0]        chan_q, chan_d;
  logic              done_q, done_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ready;

  assign sclk_s    = sclk_sync_q[SYNC-1];
  assign ss_s      = ss_sync_q[SYNC-1];
  assign mosi_s    = mosi_sync_q[SYNC-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  // Synchronized ss and its delayed copy are only trusted once both hold real samples.
  assign ready     = (warm_q == WARM_MAX);

  // NOTE: every output of this block gets a default first, so no latch is inferred
  // on paths where a state does not assign a signal.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC-2:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC-2:0], mosi};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    warm_d      = ready ? warm_q : warm_q + WARM_W'(1);
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    miso_d      = miso_q;
    cmd_d       = cmd_q;
    chan_d      = chan_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (ready) begin
          if (ss_rise) state_d = S_LOAD;
          // ss already high when reset released: sit out that frame.
          else if (ss_s) state_d = S_WAIT;
        end
      end
      S_LOAD: begin
        miso_d = 1'b0;
        if (!ss_s) begin
          state_d = S_IDLE;
        end else begin
          tx_d    = {4'b0000, sample};
          cnt_d   = 5'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Abort takes priority so an sclk edge coincident with ss falling is dropped.
        if (!ss_s) begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          miso_d = tx_q[15];
          tx_d   = {tx_q[14:0], 1'b0};
        end else if (sclk_fall) begin
          rx_d  = {rx_q[14:0], mosi_s};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            state_d = S_DONE;
            miso_d  = 1'b0;
          end
        end
      end
      S_DONE: begin
        miso_d  = 1'b0;
        cmd_d   = rx_q;
        chan_d  = rx_q[13:11];
        done_d  = 1'b1;
        state_d = ss_s ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        miso_d = 1'b0;
        if (!ss_s) state_d = S_IDLE;
      end
      default: begin
        miso_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      warm_q      <= '0;
      state_q     <= S_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
      cmd_q       <= '0;
      chan_q      <= RESET_CH;
      done_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      warm_q      <= warm_d;
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
      cmd_q       <= cmd_d;
      chan_q      <= chan_d;
      done_q      <= done_d;
    end
  end

  assign miso = miso_q;
  assign chan = chan_q;
  assign cmd  = cmd_q;
  assign done = done_q;
  assign busy = ss_s;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: drives SPI frames at clk/8 with random phase and
// compares against a per-frame model of the returned sample, cmd, chan and done count.
module tb_spi_adc_responder;

  localparam logic [2:0] RST_CH = 3'd0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        ss = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic [11:0] sample;
  logic [2:0]  chan;
  logic [15:0] cmd;
  logic        done;
  logic        busy;

  logic [11:0] mem [8];
  logic [2:0]  model_chan = RST_CH;
  logic [15:0] model_cmd = 16'h0000;
  int          exp_done = 0;
  int          done_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  spi_adc_responder #(.RESET_CH(RST_CH), .SYNC(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .sclk   (sclk),
    .ss     (ss),
    .mosi   (mosi),
    .miso   (miso),
    .sample (sample),
    .chan   (chan),
    .cmd    (cmd),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Host ADC: always presents the value of whichever channel is addressed.
  assign sample = mem[chan];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n sclk cycles (80 ns each = 8 clk); mosi taken from w MSB first, miso sampled
  // just before each falling edge. d16 records the done count before the 17th fall.
  task automatic sclk_cycles(input logic [31:0] w, input int n,
                             output logic [31:0] mw, output int d16);
    mw  = '0;
    d16 = -1;
    for (int i = 0; i < n; i++) begin
      #20 mosi = w[31-i];
      #20 sclk = 1'b1;
      #40;
      if (i == 16) d16 = done_cnt;
      mw = {mw[30:0], miso};
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [31:0] w, input int n);
    logic [31:0] exp_tx;
    logic [31:0] mw;
    int          d16;
    exp_tx = {20'h0, mem[model_chan]};
    @(posedge clk);
    #($urandom_range(1, 9));
    check("chan_pre", chan, model_chan);
    ss = 1'b1;
    #100;
    check("busy_hi", busy, 1);
    check("miso_pre", miso, 0);
    sclk_cycles(w, n, mw, d16);
    #40 ss = 1'b0;
    #100;
    if (n >= 16) begin
      check("miso_word", (mw >> (n - 16)) & 32'hffff, exp_tx);
      if (n > 16) begin
        check("miso_tail", mw & ((32'd1 << (n - 16)) - 32'd1), 0);
        check("done_at16", d16, exp_done + 1);
      end
      exp_done++;
      model_cmd  = w[31:16];
      model_chan = w[29:27];
    end else begin
      check("miso_short", mw, exp_tx >> (16 - n));
    end
    check("cmd", cmd, model_cmd);
    check("chan", chan, model_chan);
    check("done_cnt", done_cnt, exp_done);
    check("busy_lo", busy, 0);
  endtask

  initial begin
    logic [31:0] mw;
    int          d16;
    int          idx;
    for (int i = 0; i < 8; i++) mem[i] = 12'($urandom);
    mem[0] = 12'hff0;
    mem[1] = 12'h120;

    #23;
    check("rst_miso", miso, 0);
    check("rst_chan", chan, RST_CH);
    check("rst_cmd", cmd, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    #100;
    check("idle_busy", busy, 0);
    check("idle_miso", miso, 0);

    // Pipelined channel address: each frame returns the channel set by the previous one.
    run_frame({16'h0800, 16'h0000}, 16);
    run_frame({16'h1000, 16'h0000}, 16);
    run_frame($urandom, 16);

    // Short frame, then a full one to show nothing was disturbed.
    run_frame($urandom, 7);
    run_frame($urandom, 16);

    // Over-long frame: extra clocks return zero and cmd keeps the first 16 bits.
    run_frame($urandom, 20);

    // Reset in the middle of a frame with ss held high through release.
    @(posedge clk);
    #3;
    ss = 1'b1;
    #100;
    sclk_cycles($urandom, 5, mw, d16);
    reset = 1'b1;
    #20;
    check("midrst_miso", miso, 0);
    check("midrst_cmd", cmd, 0);
    check("midrst_chan", chan, RST_CH);
    check("midrst_done", done, 0);
    reset = 1'b0;
    model_chan = RST_CH;
    model_cmd  = 16'h0000;
    #100;
    check("postrst_busy", busy, 1);
    sclk_cycles($urandom, 16, mw, d16);
    check("postrst_miso", mw, 0);
    check("postrst_done", done_cnt, exp_done);
    check("postrst_cmd", cmd, 0);
    ss = 1'b0;
    #100;
    run_frame($urandom, 16);

    // Randomized frames with random phase and occasional sample updates.
    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, 7);
        mem[idx] = 12'($urandom);
      end
      run_frame($urandom, 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
